gshare_branch_predictor: RTL and testbench
==========================================

# gshare_branch_predictor

Parametrised gshare direction predictor with a direct-mapped branch target buffer (BTB), serving the rv32i fetch stage. Fetch presents a PC and receives a same-cycle taken/target prediction plus the global-history snapshot used to form it. Execute returns the resolved outcome, which trains the counters and BTB and repairs speculative history on a mispredict. It generalises the single-table bimodal predictor with configurable table and history sizes, speculative history with repair, and a hardware table-initialisation sequence.

## Interface
Parameters:
- XLEN, 32, address/target width
- PHT_INDEX_BITS, 8, log2 of pattern-history-table entries (256 two-bit counters)
- HISTORY_BITS, 8, global history length; legal range 1..PHT_INDEX_BITS
- BTB_INDEX_BITS, 4, log2 of BTB entries (16)
- COUNTER_INIT, 2'b01, counter value written by the init sweep (weakly not-taken)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- init_done  out  1  high once the PHT init sweep has completed
- fetch_valid  in  1  fetch PC is valid this cycle
- fetch_pc  in  XLEN  PC being fetched
- pred_taken  out  1  predicted taken
- pred_target  out  XLEN  predicted next PC
- pred_ghr  out  HISTORY_BITS  history snapshot used for this prediction, carried down the pipe
- update_valid  in  1  a resolved conditional branch is presented
- update_pc  in  XLEN  PC of the resolved branch
- update_taken  in  1  actual direction
- update_target  in  XLEN  actual taken target
- update_ghr  in  HISTORY_BITS  pred_ghr captured when this branch was predicted
- update_mispredict  in  1  direction or target was mispredicted; qualified by update_valid

## Operation
- PHT index: fetch_pc[PHT_INDEX_BITS+1:2] XOR zero-extended ghr; update index uses update_pc and update_ghr identically.
- Counters: 2-bit saturating; taken increments (saturates at 3), not-taken decrements (saturates at 0); counter[1] is the direction.
- BTB: direct-mapped; index pc[BTB_INDEX_BITS+1:2], tag pc[XLEN-1:BTB_INDEX_BITS+2], per-entry valid bit. On update_valid && update_taken the entry is written (valid=1, tag, update_target), overwriting any occupant. Not-taken updates leave the BTB unchanged.
- Prediction: hit = valid && tag match. pred_taken = hit && counter[1]; pred_target = BTB target when pred_taken, else fetch_pc+4 (mod 2^XLEN). pred_ghr = current ghr.
- Speculative history: on fetch_valid && init_done, ghr <= {ghr[HISTORY_BITS-2:0], pred_taken}.
- Repair: on update_valid && update_mispredict, ghr <= {update_ghr[HISTORY_BITS-2:0], update_taken}; takes priority over a same-cycle fetch shift.
- FSM: INIT -> READY. INIT writes COUNTER_INIT to entry init_idx, init_idx increments each cycle; after entry 2^PHT_INDEX_BITS-1 the FSM moves to READY and init_done rises. No return to INIT except via reset.
- During INIT: pred_taken=0, pred_target=fetch_pc+4, ghr frozen, update_valid ignored.

## Timing
- Reset (async assert): state=INIT, init_idx=0, init_done=0, ghr=0, all BTB valid=0. pred_taken=0, pred_target=fetch_pc+4, pred_ghr=0 while reset is held.
- Init latency: init_done high on the 2^PHT_INDEX_BITS-th rising edge after rst_n deasserts (256 edges at default).
- Prediction: combinational, zero-cycle from fetch_pc.
- Training: PHT/BTB/ghr written on the edge where update_valid is sampled; visible to predictions in the next cycle. Same-cycle read of an entry being written returns the old value (no bypass).
- Simultaneous update and fetch to the same PHT or BTB entry: write completes, fetch sees pre-write contents.
- Reset asserted mid-sweep or mid-operation: all state cleared immediately; sweep restarts from entry 0.

## Configuration
- GSHARE_BTB_EN defined: BTB instantiated; behaviour exactly as above.
- Undefined: no BTB storage; pred_taken = counter[1] (no hit qualification), pred_target = fetch_pc+4 always (decode redirects to the taken target); update_target ignored; PHT, history and FSM unchanged.

## Test plan
- Reset then idle -> init_done low for 255 edges, high on edge 256; pred_taken=0, pred_target=fetch_pc+4 throughout sweep.
- After init, update_valid with pc=0x100, taken, target=0x200, ghr=0, twice -> fetch 0x100 with ghr=0 gives pred_taken=1, pred_target=0x200 (counter 01->10->11).
- Saturation: four not-taken updates on a counter at 11 -> direction flips after the second; counter holds 00; pred_target=0x104.
- Fetch with pred_taken=1 and simultaneous update_mispredict, update_ghr=8'h5A, update_taken=0 -> next ghr=8'hB4 (repair wins over shift).
- BTB conflict: train 0x100 then 0x140 (same index, different tag, BTB_INDEX_BITS=4) -> fetch 0x100 misses, pred_taken=0, target 0x104.
- Assert rst_n low mid-sweep at init_idx=100 -> init_done=0, ghr=0, BTB valid cleared; sweep restarts and init_done rises 256 edges after release.

Source files
------------

// File: rtl/gshare_branch_predictor_if.sv
// Fetch/predict/update bundle between the fetch stage, execute and the gshare predictor.
// The predictor is the slave side; the pipeline (or a bench) drives it through the master modport.
interface gshare_branch_predictor_if #(
  parameter int XLEN         = 32,
  parameter int HISTORY_BITS = 8
);
  logic                    init_done;
  logic                    fetch_valid;
  logic [XLEN-1:0]         fetch_pc;
  logic                    pred_taken;
  logic [XLEN-1:0]         pred_target;
  logic [HISTORY_BITS-1:0] pred_ghr;
  logic                    update_valid;
  logic [XLEN-1:0]         update_pc;
  logic                    update_taken;
  logic [XLEN-1:0]         update_target;
  logic [HISTORY_BITS-1:0] update_ghr;
  logic                    update_mispredict;

  modport master (
    input  init_done, pred_taken, pred_target, pred_ghr,
    output fetch_valid, fetch_pc, update_valid, update_pc, update_taken,
           update_target, update_ghr, update_mispredict
  );

  modport slave (
    output init_done, pred_taken, pred_target, pred_ghr,
    input  fetch_valid, fetch_pc, update_valid, update_pc, update_taken,
           update_target, update_ghr, update_mispredict
  );
endinterface

// File: rtl/gshare_branch_predictor.sv
// Gshare direction predictor with speculative global history, mispredict repair and a PHT init sweep.
// Optional direct-mapped BTB enabled by defining GSHARE_BTB_EN; otherwise target is always fetch_pc+4.
module gshare_branch_predictor #(
  parameter int         XLEN           = 32,
  parameter int         PHT_INDEX_BITS = 8,
  parameter int         HISTORY_BITS   = 8,
  parameter int         BTB_INDEX_BITS = 4,
  parameter logic [1:0] COUNTER_INIT   = 2'b01
) (
  input logic                      clk,
  input logic                      rst_n,
  gshare_branch_predictor_if.slave bp
);

  localparam int PHT_ENTRIES = 1 << PHT_INDEX_BITS;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]                state_q, state_d;
  logic [PHT_INDEX_BITS-1:0] init_idx_q, init_idx_d;
  logic [HISTORY_BITS-1:0]   ghr_q, ghr_d;
  logic [1:0]                pht_q [PHT_ENTRIES];

  logic                      ready;
  logic [PHT_INDEX_BITS-1:0] fetch_idx;
  logic [PHT_INDEX_BITS-1:0] upd_idx;
  logic [1:0]                fetch_ctr;
  logic [1:0]                upd_ctr;
  logic [1:0]                upd_ctr_nxt;
  logic [XLEN-1:0]           pc_plus4;
  logic                      dir_taken;
  logic [XLEN-1:0]           taken_target;

  assign ready     = (state_q == ST_READY);
  assign fetch_idx = bp.fetch_pc[PHT_INDEX_BITS+1:2] ^ PHT_INDEX_BITS'(ghr_q);
  assign upd_idx   = bp.update_pc[PHT_INDEX_BITS+1:2] ^ PHT_INDEX_BITS'(bp.update_ghr);
  assign fetch_ctr = pht_q[fetch_idx];
  assign upd_ctr   = pht_q[upd_idx];
  assign pc_plus4  = bp.fetch_pc + XLEN'(4);

  always_comb begin
    upd_ctr_nxt = upd_ctr;
    if (bp.update_taken) begin
      if (upd_ctr != 2'b11) upd_ctr_nxt = upd_ctr + 2'b01;
    end else begin
      if (upd_ctr != 2'b00) upd_ctr_nxt = upd_ctr - 2'b01;
    end
  end

`ifdef GSHARE_BTB_EN
  localparam int BTB_ENTRIES = 1 << BTB_INDEX_BITS;
  localparam int TAG_BITS    = XLEN - BTB_INDEX_BITS - 2;

  logic [BTB_ENTRIES-1:0]    btb_vld_q;
  logic [TAG_BITS-1:0]       btb_tag_q [BTB_ENTRIES];
  logic [XLEN-1:0]           btb_tgt_q [BTB_ENTRIES];
  logic [BTB_INDEX_BITS-1:0] fetch_btb_idx;
  logic [BTB_INDEX_BITS-1:0] upd_btb_idx;
  logic                      btb_hit;
  logic                      btb_wr;

  assign fetch_btb_idx = bp.fetch_pc[BTB_INDEX_BITS+1:2];
  assign upd_btb_idx   = bp.update_pc[BTB_INDEX_BITS+1:2];
  assign btb_hit       = btb_vld_q[fetch_btb_idx] &&
                         (btb_tag_q[fetch_btb_idx] == bp.fetch_pc[XLEN-1:BTB_INDEX_BITS+2]);
  assign btb_wr        = ready && bp.update_valid && bp.update_taken;
  assign dir_taken     = btb_hit && fetch_ctr[1];
  assign taken_target  = btb_tgt_q[fetch_btb_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btb_vld_q <= '0;
    end else if (btb_wr) begin
      btb_vld_q[upd_btb_idx] <= 1'b1;
    end
  end

  // Tag/target payload needs no reset: the valid bit gates every use.
  always_ff @(posedge clk) begin
    if (btb_wr) begin
      btb_tag_q[upd_btb_idx] <= bp.update_pc[XLEN-1:BTB_INDEX_BITS+2];
      btb_tgt_q[upd_btb_idx] <= bp.update_target;
    end
  end
`else
  assign dir_taken    = fetch_ctr[1];
  assign taken_target = pc_plus4;
`endif

  assign bp.init_done   = ready;
  assign bp.pred_taken  = ready && dir_taken;
  assign bp.pred_target = bp.pred_taken ? taken_target : pc_plus4;
  assign bp.pred_ghr    = ghr_q;

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    ghr_d      = ghr_q;
    if (!ready) begin
      init_idx_d = init_idx_q + PHT_INDEX_BITS'(1);
      if (init_idx_q == '1) state_d = ST_READY;
    end else if (bp.update_valid && bp.update_mispredict) begin
      // Repair rebuilds history from the snapshot the branch was predicted with.
      ghr_d = HISTORY_BITS'({bp.update_ghr, bp.update_taken});
    end else if (bp.fetch_valid) begin
      ghr_d = HISTORY_BITS'({ghr_q, bp.pred_taken});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
      ghr_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      ghr_q      <= ghr_d;
    end
  end

  // Counters are not reset; the sweep after every reset rewrites all of them.
  always_ff @(posedge clk) begin
    if (!ready) begin
      pht_q[init_idx_q] <= COUNTER_INIT;
    end else if (bp.update_valid) begin
      pht_q[upd_idx] <= upd_ctr_nxt;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{bp.update_pc, bp.update_target};

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Self-checking bench: directed scenarios plus random traffic against a table-level reference model.
module tb_gshare_branch_predictor;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  gshare_branch_predictor_if #(.XLEN(32), .HISTORY_BITS(8)) bp_if ();

  gshare_branch_predictor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp_if)
  );

  // Reference model: counter values as integers, BTB as plain arrays.
  int          pht_m [256];
  bit          btb_v [16];
  int unsigned btb_tag [16];
  int unsigned btb_tgt [16];
  int          ghr_m;
  bit          ready_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input int unsigned pc, input int g);
    return ((pc >> 2) ^ g) & 255;
  endfunction

  function automatic bit model_taken(input int unsigned pc);
    bit t;
    t = ready_m && (pht_m[idx_of(pc, ghr_m)] >= 2);
`ifdef GSHARE_BTB_EN
    t = t && btb_v[(pc >> 2) & 15] && (btb_tag[(pc >> 2) & 15] == (pc >> 6));
`endif
    return t;
  endfunction

  function automatic int unsigned model_target(input int unsigned pc);
`ifdef GSHARE_BTB_EN
    if (model_taken(pc)) return btb_tgt[(pc >> 2) & 15];
`endif
    return pc + 4;
  endfunction

  task automatic model_reset();
    ready_m = 1'b0;
    ghr_m   = 0;
    for (int i = 0; i < 16; i++) btb_v[i] = 1'b0;
  endtask

  task automatic idle_inputs();
    bp_if.fetch_valid       = 1'b0;
    bp_if.fetch_pc          = 32'h0;
    bp_if.update_valid      = 1'b0;
    bp_if.update_pc         = 32'h0;
    bp_if.update_taken      = 1'b0;
    bp_if.update_target     = 32'h0;
    bp_if.update_ghr        = 8'h0;
    bp_if.update_mispredict = 1'b0;
  endtask

  // One cycle: drive, check predictions against the model, clock, advance the model.
  task automatic step(input bit fv, input int unsigned fpc, input bit uv, input int unsigned upc,
                      input bit ut, input int unsigned utgt, input int ughr, input bit um);
    bit          exp_t;
    int          i;
    bp_if.fetch_valid       = fv;
    bp_if.fetch_pc          = fpc;
    bp_if.update_valid      = uv;
    bp_if.update_pc         = upc;
    bp_if.update_taken      = ut;
    bp_if.update_target     = utgt;
    bp_if.update_ghr        = 8'(ughr);
    bp_if.update_mispredict = um;
    #2;
    exp_t = model_taken(fpc);
    chk("pred_taken", 32'(bp_if.pred_taken), 32'(exp_t));
    chk("pred_target", bp_if.pred_target, model_target(fpc));
    chk("pred_ghr", 32'(bp_if.pred_ghr), 32'(ghr_m));
    chk("init_done", 32'(bp_if.init_done), 32'(ready_m));
    @(posedge clk);
    if (ready_m) begin
      if (uv) begin
        i = idx_of(upc, ughr & 255);
        if (ut) pht_m[i] = (pht_m[i] == 3) ? 3 : pht_m[i] + 1;
        else    pht_m[i] = (pht_m[i] == 0) ? 0 : pht_m[i] - 1;
`ifdef GSHARE_BTB_EN
        if (ut) begin
          btb_v[(upc >> 2) & 15]   = 1'b1;
          btb_tag[(upc >> 2) & 15] = upc >> 6;
          btb_tgt[(upc >> 2) & 15] = utgt;
        end
`endif
      end
      if (uv && um)  ghr_m = ((ughr << 1) | int'(ut)) & 255;
      else if (fv)   ghr_m = ((ghr_m << 1) | int'(exp_t)) & 255;
    end
    #1;
  endtask

  task automatic peek(input int unsigned fpc);
    idle_inputs();
    bp_if.fetch_pc = fpc;
    #2;
  endtask

  // Runs the init sweep from a just-released reset, with random traffic that must be ignored.
  task automatic sweep();
    int unsigned pc;
    for (int e = 1; e <= 256; e++) begin
      pc = $urandom & 32'hFFFF_FFFC;
      bp_if.fetch_valid       = 1'b1;
      bp_if.fetch_pc          = pc;
      bp_if.update_valid      = 1'b1;
      bp_if.update_pc         = $urandom & 32'hFFFF_FFFC;
      bp_if.update_taken      = 1'($urandom);
      bp_if.update_target     = $urandom;
      bp_if.update_ghr        = 8'($urandom);
      bp_if.update_mispredict = 1'($urandom);
      #1;
      chk("sweep_pred_taken", 32'(bp_if.pred_taken), 32'h0);
      chk("sweep_pred_target", bp_if.pred_target, pc + 4);
      chk("sweep_ghr", 32'(bp_if.pred_ghr), 32'h0);
      @(posedge clk);
      #1;
      chk("sweep_init_done", 32'(bp_if.init_done), 32'(e == 256));
    end
    for (int i = 0; i < 256; i++) pht_m[i] = 1;
    ready_m = 1'b1;
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, tests %0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned pcs [4];
    int unsigned fpc, upc;
    pcs[0] = 32'h100; pcs[1] = 32'h140; pcs[2] = 32'h200; pcs[3] = 32'h104;

    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    bp_if.fetch_pc = 32'h1234;
    #23;
    chk("rst_init_done", 32'(bp_if.init_done), 32'h0);
    chk("rst_ghr", 32'(bp_if.pred_ghr), 32'h0);
    chk("rst_pred_taken", 32'(bp_if.pred_taken), 32'h0);
    chk("rst_pred_target", bp_if.pred_target, 32'h1238);
    @(negedge clk);
    rst_n = 1'b1;
    sweep();

    // Two taken trainings move the counter 01 -> 10 -> 11.
    step(0, 32'h100, 1, 32'h100, 1, 32'h200, 0, 0);
    step(0, 32'h100, 1, 32'h100, 1, 32'h200, 0, 0);
    peek(32'h100);
    chk("train_taken", 32'(bp_if.pred_taken), 32'h1);
`ifdef GSHARE_BTB_EN
    chk("train_target", bp_if.pred_target, 32'h200);
`else
    chk("train_target", bp_if.pred_target, 32'h104);
`endif

    // Four not-taken trainings saturate the counter at 00.
    for (int k = 0; k < 4; k++) step(0, 32'h100, 1, 32'h100, 0, 0, 0, 0);
    peek(32'h100);
    chk("sat_taken", 32'(bp_if.pred_taken), 32'h0);
    chk("sat_target", bp_if.pred_target, 32'h104);
    step(0, 32'h100, 1, 32'h100, 1, 32'h200, 0, 0);
    peek(32'h100);
    chk("sat_floor", 32'(bp_if.pred_taken), 32'h0);

    // Repair beats a same-cycle speculative shift.
    step(0, 32'h100, 1, 32'h100, 1, 32'h200, 0, 0);
    step(1, 32'h100, 1, 32'h300, 0, 0, 8'h5A, 1);
    peek(32'h100);
    chk("repair_ghr", 32'(bp_if.pred_ghr), 32'hB4);
    step(0, 32'h0, 1, 32'h300, 0, 0, 0, 1);

    // BTB conflict: 0x140 evicts 0x100 from the shared entry.
    step(0, 32'h100, 1, 32'h100, 1, 32'h200, 0, 0);
    step(0, 32'h140, 1, 32'h140, 1, 32'h300, 0, 0);
    peek(32'h100);
    chk("conflict_target", bp_if.pred_target, 32'h104);
`ifdef GSHARE_BTB_EN
    chk("conflict_taken", 32'(bp_if.pred_taken), 32'h0);
`else
    chk("conflict_taken", 32'(bp_if.pred_taken), 32'h1);
`endif

    for (int k = 0; k < 400; k++) begin
      fpc = ($urandom_range(0, 4) == 4) ? ($urandom & 32'hFFFF_FFFC) : pcs[$urandom_range(0, 3)];
      upc = pcs[$urandom_range(0, 3)];
      step(1'($urandom), fpc, 1'($urandom), upc, 1'($urandom), $urandom & 32'hFFFF_FFFC,
           int'($urandom_range(0, 255)) & ((k < 200) ? 3 : 255), 1'($urandom_range(0, 3) == 0));
    end

    // Reset mid-sweep at init_idx = 100.
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("midop_rst_ghr", 32'(bp_if.pred_ghr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("midsweep_init_done", 32'(bp_if.init_done), 32'h0);
    rst_n = 1'b0;
    bp_if.fetch_pc = 32'h100;
    #2;
    chk("midsweep_rst_done", 32'(bp_if.init_done), 32'h0);
    chk("midsweep_rst_ghr", 32'(bp_if.pred_ghr), 32'h0);
    chk("midsweep_rst_taken", 32'(bp_if.pred_taken), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sweep();

    step(0, 32'h100, 0, 0, 0, 0, 0, 0);
    peek(32'h140);
    chk("post_rst_btb_clear", 32'(bp_if.pred_taken), 32'h0);
    step(0, 32'h100, 1, 32'h100, 1, 32'h280, 0, 0);
    step(1, 32'h100, 0, 0, 0, 0, 0, 0);
    step(1, 32'h104, 1, 32'h104, 0, 0, 8'h02, 1);
    step(1, 32'h100, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
